tl_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one TileLink Uncached Heavyweight (TL-UH) master port between the instruction cache (m0) and the data cache/LSU (m1). It grants one requester at a time and locks the grant for the whole transaction, including every D-channel response beat. It forwards the owner's A channel to the bus and steers D beats back to the owner only. It sits between the frontend/LSU bus masters and the system interconnect.

---
 rtl/tl_mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_tl_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tl_mem_arbiter
//
// Shares one TL-UH master port between the instruction cache (m0) and the
// data cache / LSU (m1). One requester owns the bus at a time, and keeps it
// from the A request until its last D response beat has been accepted.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> ties go to the requester that did not win last
//                       undefined -> fixed priority, m0 wins ties
//
// Ports:
//   cpu_clk_i, cpu_rst_i        clock, asynchronous active-high reset
//   m0_a_*, m1_a_*              requester A channels (payload, valid in / ready out)
//   m0_d_*, m1_d_*              requester D channels (payload, valid out / ready in)
//   bus_a_*                     A channel towards the interconnect
//   bus_d_*                     D channel from the interconnect
// -----------------------------------------------------------------------------
module tl_mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = 7
) (
    input  logic                  cpu_clk_i,
    input  logic                  cpu_rst_i,

    input  logic [2:0]            m0_a_opcode,
    input  logic [2:0]            m0_a_param,
    input  logic [3:0]            m0_a_size,
    input  logic [31:0]           m0_a_address,
    input  logic [DATA_W/8-1:0]   m0_a_mask,
    input  logic [DATA_W-1:0]     m0_a_data,
    input  logic                  m0_a_corrupt,
    input  logic                  m0_a_valid,
    output logic                  m0_a_ready,
    output logic [2:0]            m0_d_opcode,
    output logic [1:0]            m0_d_param,
    output logic [3:0]            m0_d_size,
    output logic                  m0_d_denied,
    output logic [DATA_W-1:0]     m0_d_data,
    output logic                  m0_d_corrupt,
    output logic                  m0_d_valid,
    input  logic                  m0_d_ready,

    input  logic [2:0]            m1_a_opcode,
    input  logic [2:0]            m1_a_param,
    input  logic [3:0]            m1_a_size,
    input  logic [31:0]           m1_a_address,
    input  logic [DATA_W/8-1:0]   m1_a_mask,
    input  logic [DATA_W-1:0]     m1_a_data,
    input  logic                  m1_a_corrupt,
    input  logic                  m1_a_valid,
    output logic                  m1_a_ready,
    output logic [2:0]            m1_d_opcode,
    output logic [1:0]            m1_d_param,
    output logic [3:0]            m1_d_size,
    output logic                  m1_d_denied,
    output logic [DATA_W-1:0]     m1_d_data,
    output logic                  m1_d_corrupt,
    output logic                  m1_d_valid,
    input  logic                  m1_d_ready,

    output logic [2:0]            bus_a_opcode,
    output logic [2:0]            bus_a_param,
    output logic [3:0]            bus_a_size,
    output logic [31:0]           bus_a_address,
    output logic [DATA_W/8-1:0]   bus_a_mask,
    output logic [DATA_W-1:0]     bus_a_data,
    output logic                  bus_a_corrupt,
    output logic                  bus_a_valid,
    input  logic                  bus_a_ready,
    input  logic [2:0]            bus_d_opcode,
    input  logic [1:0]            bus_d_param,
    input  logic [3:0]            bus_d_size,
    input  logic                  bus_d_denied,
    input  logic [DATA_W-1:0]     bus_d_data,
    input  logic                  bus_d_corrupt,
    input  logic                  bus_d_valid,
    output logic                  bus_d_ready
);

    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int LOG_BB     = $clog2(BEAT_BYTES);
    localparam int BEATS_W    = MAX_SIZE + 1;
    localparam logic [2:0] OP_GET = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        A_PHASE = 2'd1,
        D_PHASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [BEATS_W-1:0]   beats_left_q, beats_left_d;
    logic                 rr_last_q, rr_last_d;

    logic                 in_a, in_d;
    logic                 sel;
    logic                 own_a_valid, own_d_ready;
    logic                 winner;
    logic                 a_fire, d_fire;

    // Number of D beats the bus returns for an A message. Only a Get in the
    // legal size range spans several beats; everything else (Puts, oversize
    // requests) is answered with a single beat.
    function automatic logic [BEATS_W-1:0] resp_beats(input logic [2:0] op,
                                                      input logic [3:0] size);
        logic [BEATS_W-1:0] n;
        n = BEATS_W'(1);
        if (op == OP_GET && int'(size) <= MAX_SIZE && int'(size) > LOG_BB) begin
            n = BEATS_W'(1) << (int'(size) - LOG_BB);
        end
        return n;
    endfunction

    assign in_a = (state_q == A_PHASE);
    assign in_d = (state_q == D_PHASE);

    // In IDLE the payload mux parks on m0 so the outputs are never floating.
    assign sel = (state_q != IDLE) && owner_q;

    assign own_a_valid = sel ? m1_a_valid : m0_a_valid;
    assign own_d_ready = sel ? m1_d_ready : m0_d_ready;

    // A channel: owner's payload forwarded unchanged.
    assign bus_a_opcode  = sel ? m1_a_opcode  : m0_a_opcode;
    assign bus_a_param   = sel ? m1_a_param   : m0_a_param;
    assign bus_a_size    = sel ? m1_a_size    : m0_a_size;
    assign bus_a_address = sel ? m1_a_address : m0_a_address;
    assign bus_a_mask    = sel ? m1_a_mask    : m0_a_mask;
    assign bus_a_data    = sel ? m1_a_data    : m0_a_data;
    assign bus_a_corrupt = sel ? m1_a_corrupt : m0_a_corrupt;

    // Handshake qualifiers depend on the state register only, so an async
    // reset drops every valid/ready immediately.
    assign bus_a_valid = in_a && own_a_valid;
    assign m0_a_ready  = in_a && !owner_q && bus_a_ready;
    assign m1_a_ready  = in_a &&  owner_q && bus_a_ready;

    assign bus_d_ready = in_d && own_d_ready;
    assign m0_d_valid  = in_d && !owner_q && bus_d_valid;
    assign m1_d_valid  = in_d &&  owner_q && bus_d_valid;

    // D payload is broadcast; only the owner sees d_valid.
    assign m0_d_opcode  = bus_d_opcode;
    assign m0_d_param   = bus_d_param;
    assign m0_d_size    = bus_d_size;
    assign m0_d_denied  = bus_d_denied;
    assign m0_d_data    = bus_d_data;
    assign m0_d_corrupt = bus_d_corrupt;
    assign m1_d_opcode  = bus_d_opcode;
    assign m1_d_param   = bus_d_param;
    assign m1_d_size    = bus_d_size;
    assign m1_d_denied  = bus_d_denied;
    assign m1_d_data    = bus_d_data;
    assign m1_d_corrupt = bus_d_corrupt;

    assign a_fire = bus_a_valid && bus_a_ready;
    assign d_fire = bus_d_valid && bus_d_ready;

    // Arbitration: a lone requester always wins; ties depend on the policy.
    always_comb begin
        winner = 1'b0;
        if (m0_a_valid && m1_a_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = !rr_last_q;
`else
            winner = 1'b0;
`endif
        end else begin
            winner = m1_a_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        rr_last_d    = rr_last_q;
        case (state_q)
            IDLE: begin
                if (m0_a_valid || m1_a_valid) begin
                    owner_d = winner;
                    state_d = A_PHASE;
                end
            end
            A_PHASE: begin
                if (a_fire) begin
                    beats_left_d = resp_beats(bus_a_opcode, bus_a_size);
                    state_d      = D_PHASE;
                end else if (!own_a_valid) begin
                    // Owner withdrew before the handshake: release the grant.
                    state_d = IDLE;
                end
            end
            D_PHASE: begin
                if (d_fire) begin
                    if (beats_left_q <= BEATS_W'(1)) begin
                        beats_left_d = '0;
                        rr_last_d    = owner_q;
                        state_d      = IDLE;
                    end else begin
                        beats_left_d = beats_left_q - BEATS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            beats_left_q <= '0;
            rr_last_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            rr_last_q    <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_mem_arbiter
//
// Directed testbench for tl_mem_arbiter (DATA_W = 32, MAX_SIZE = 7). Inputs
// change one time unit after the rising edge; outputs are sampled before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_tl_mem_arbiter;

    logic        clk;
    logic        rst;

    logic [2:0]  m0_a_opcode, m0_a_param;
    logic [3:0]  m0_a_size;
    logic [31:0] m0_a_address;
    logic [3:0]  m0_a_mask;
    logic [31:0] m0_a_data;
    logic        m0_a_corrupt, m0_a_valid, m0_a_ready;
    logic [2:0]  m0_d_opcode;
    logic [1:0]  m0_d_param;
    logic [3:0]  m0_d_size;
    logic        m0_d_denied;
    logic [31:0] m0_d_data;
    logic        m0_d_corrupt, m0_d_valid, m0_d_ready;

    logic [2:0]  m1_a_opcode, m1_a_param;
    logic [3:0]  m1_a_size;
    logic [31:0] m1_a_address;
    logic [3:0]  m1_a_mask;
    logic [31:0] m1_a_data;
    logic        m1_a_corrupt, m1_a_valid, m1_a_ready;
    logic [2:0]  m1_d_opcode;
    logic [1:0]  m1_d_param;
    logic [3:0]  m1_d_size;
    logic        m1_d_denied;
    logic [31:0] m1_d_data;
    logic        m1_d_corrupt, m1_d_valid, m1_d_ready;

    logic [2:0]  bus_a_opcode, bus_a_param;
    logic [3:0]  bus_a_size;
    logic [31:0] bus_a_address;
    logic [3:0]  bus_a_mask;
    logic [31:0] bus_a_data;
    logic        bus_a_corrupt, bus_a_valid, bus_a_ready;
    logic [2:0]  bus_d_opcode;
    logic [1:0]  bus_d_param;
    logic [3:0]  bus_d_size;
    logic        bus_d_denied;
    logic [31:0] bus_d_data;
    logic        bus_d_corrupt, bus_d_valid, bus_d_ready;

    int n_checks = 0;
    int n_fail   = 0;

    tl_mem_arbiter #(.DATA_W(32), .MAX_SIZE(7)) dut (
        .cpu_clk_i(clk), .cpu_rst_i(rst),
        .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
        .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
        .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .bus_a_opcode(bus_a_opcode), .bus_a_param(bus_a_param), .bus_a_size(bus_a_size),
        .bus_a_address(bus_a_address), .bus_a_mask(bus_a_mask), .bus_a_data(bus_a_data),
        .bus_a_corrupt(bus_a_corrupt), .bus_a_valid(bus_a_valid), .bus_a_ready(bus_a_ready),
        .bus_d_opcode(bus_d_opcode), .bus_d_param(bus_d_param), .bus_d_size(bus_d_size),
        .bus_d_denied(bus_d_denied), .bus_d_data(bus_d_data), .bus_d_corrupt(bus_d_corrupt),
        .bus_d_valid(bus_d_valid), .bus_d_ready(bus_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_a_opcode = '0; m0_a_param = '0; m0_a_size = '0; m0_a_address = '0;
        m0_a_mask = '0; m0_a_data = '0; m0_a_corrupt = 1'b0; m0_a_valid = 1'b0;
        m0_d_ready = 1'b0;
        m1_a_opcode = '0; m1_a_param = '0; m1_a_size = '0; m1_a_address = '0;
        m1_a_mask = '0; m1_a_data = '0; m1_a_corrupt = 1'b0; m1_a_valid = 1'b0;
        m1_d_ready = 1'b0;
        bus_a_ready = 1'b0;
        bus_d_opcode = '0; bus_d_param = '0; bus_d_size = '0; bus_d_denied = 1'b0;
        bus_d_data = '0; bus_d_corrupt = 1'b0; bus_d_valid = 1'b0;
    endtask

    task automatic set_a0(input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [31:0] data);
        m0_a_opcode = op; m0_a_size = sz; m0_a_address = addr;
        m0_a_data = data; m0_a_mask = 4'hF;
    endtask

    task automatic set_a1(input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [31:0] data);
        m1_a_opcode = op; m1_a_size = sz; m1_a_address = addr;
        m1_a_data = data; m1_a_mask = 4'hF;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Reset: with requests and a D beat pending, nothing handshakes.
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_a_valid = 1'b1; m1_a_valid = 1'b1; bus_a_ready = 1'b1;
        bus_d_valid = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        tick();
        n_checks++; if (bus_a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_a_valid: got %b want 0", bus_a_valid); end
        n_checks++; if (bus_d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_bus_d_ready: got %b want 0", bus_d_ready); end
        n_checks++; if ({m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid} !== 4'b0000) begin n_fail++; $display("FAIL rst_m_hs: got %b want 0000", {m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid}); end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    // m0 Get of a 128-byte line: 32 beats, all to m0.
    task automatic test_get_burst();
        int bad_route;
        bad_route = 0;
        set_a0(3'd4, 4'd7, 32'h0000_1080, 32'h0);
        m0_a_valid = 1'b1;
        #1;
        n_checks++; if (bus_a_valid !== 1'b0) begin n_fail++; $display("FAIL get_no_a_in_idle: got %b want 0", bus_a_valid); end
        tick();
        n_checks++; if (bus_a_valid !== 1'b1) begin n_fail++; $display("FAIL get_a_valid: got %b want 1", bus_a_valid); end
        n_checks++; if (bus_a_address !== 32'h0000_1080) begin n_fail++; $display("FAIL get_a_address: got %h want 00001080", bus_a_address); end
        n_checks++; if (bus_a_size !== 4'd7) begin n_fail++; $display("FAIL get_a_size: got %0d want 7", bus_a_size); end
        bus_a_ready = 1'b1;
        #1;
        n_checks++; if (m0_a_ready !== 1'b1) begin n_fail++; $display("FAIL get_m0_a_ready: got %b want 1", m0_a_ready); end
        tick();
        m0_a_valid = 1'b0; bus_a_ready = 1'b0;
        m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        bus_d_valid = 1'b1; bus_d_opcode = 3'd1;
        for (int i = 0; i < 32; i++) begin
            bus_d_data = 32'h0000_0100 + 32'(i);
            #1;
            if (m0_d_valid !== 1'b1 || m1_d_valid !== 1'b0 || bus_d_ready !== 1'b1 ||
                m0_d_data !== 32'h0000_0100 + 32'(i)) begin
                bad_route++;
            end
            tick();
        end
        n_checks++; if (bad_route !== 0) begin n_fail++; $display("FAIL get_beat_routing: got %0d bad beats want 0", bad_route); end
        n_checks++; if (bus_d_ready !== 1'b0 || m0_d_valid !== 1'b0) begin n_fail++; $display("FAIL get_idle_after_32: got d_ready=%b m0_d_valid=%b want 0 0", bus_d_ready, m0_d_valid); end
        clear_inputs();
        tick();
    endtask

    // m1 PutFullData under A backpressure, single AccessAck.
    task automatic test_put_backpressure();
        int bad_stall;
        bad_stall = 0;
        set_a1(3'd0, 4'd2, 32'h0000_2000, 32'hDEAD_BEEF);
        m1_a_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (bus_a_valid !== 1'b1 || m1_a_ready !== 1'b0 || m0_a_ready !== 1'b0 ||
                bus_a_data !== 32'hDEAD_BEEF) begin
                bad_stall++;
            end
            tick();
        end
        n_checks++; if (bad_stall !== 0) begin n_fail++; $display("FAIL put_stall: got %0d bad cycles want 0", bad_stall); end
        bus_a_ready = 1'b1;
        #1;
        n_checks++; if (m1_a_ready !== 1'b1) begin n_fail++; $display("FAIL put_m1_a_ready: got %b want 1", m1_a_ready); end
        n_checks++; if (bus_a_opcode !== 3'd0) begin n_fail++; $display("FAIL put_opcode: got %0d want 0", bus_a_opcode); end
        tick();
        m1_a_valid = 1'b0; bus_a_ready = 1'b0;
        m1_d_ready = 1'b1; m0_d_ready = 1'b1;
        bus_d_valid = 1'b1; bus_d_opcode = 3'd0;
        #1;
        n_checks++; if (m1_d_valid !== 1'b1 || m0_d_valid !== 1'b0) begin n_fail++; $display("FAIL put_ack_route: got m1=%b m0=%b want 1 0", m1_d_valid, m0_d_valid); end
        tick();
        n_checks++; if (bus_d_ready !== 1'b0) begin n_fail++; $display("FAIL put_idle_after_ack: got %b want 0", bus_d_ready); end
        clear_inputs();
        tick();
    endtask

    // Both requesters tie in IDLE four times in a row.
    task automatic test_tie_arbitration();
        logic [31:0] exp_addr;
        reset_dut();
        set_a0(3'd4, 4'd2, 32'h0000_A000, 32'h0);
        set_a1(3'd4, 4'd2, 32'h0000_B000, 32'h0);
        m0_a_valid = 1'b1; m1_a_valid = 1'b1;
        m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            exp_addr = (k % 2 == 1) ? 32'h0000_B000 : 32'h0000_A000;
`else
            exp_addr = 32'h0000_A000;
`endif
            n_checks++; if (bus_a_valid !== 1'b1 || bus_a_address !== exp_addr) begin n_fail++; $display("FAIL tie_grant_%0d: got valid=%b addr=%h want 1 %h", k, bus_a_valid, bus_a_address, exp_addr); end
            bus_a_ready = 1'b1;
            tick();
            bus_a_ready = 1'b0; bus_d_valid = 1'b1;
            tick();
            bus_d_valid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    // m1 Get with D backpressure: beat held, delivered once.
    task automatic test_d_backpressure();
        set_a1(3'd4, 4'd2, 32'h0000_C000, 32'h0);
        m1_a_valid = 1'b1;
        tick();
        bus_a_ready = 1'b1;
        tick();
        m1_a_valid = 1'b0; bus_a_ready = 1'b0;
        bus_d_valid = 1'b1; bus_d_opcode = 3'd1; bus_d_data = 32'h1234_5678;
        m1_d_ready = 1'b0; m0_d_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            #1;
            n_checks++; if (bus_d_ready !== 1'b0 || m1_d_valid !== 1'b1) begin n_fail++; $display("FAIL dbp_stall_%0d: got d_ready=%b m1_d_valid=%b want 0 1", j, bus_d_ready, m1_d_valid); end
            tick();
        end
        m1_d_ready = 1'b1;
        #1;
        n_checks++; if (bus_d_ready !== 1'b1 || m1_d_data !== 32'h1234_5678 || m0_d_valid !== 1'b0) begin n_fail++; $display("FAIL dbp_deliver: got d_ready=%b data=%h m0_d_valid=%b want 1 12345678 0", bus_d_ready, m1_d_data, m0_d_valid); end
        tick();
        n_checks++; if (bus_d_ready !== 1'b0) begin n_fail++; $display("FAIL dbp_single_beat: got %b want 0", bus_d_ready); end
        clear_inputs();
        tick();
    endtask

    // Async reset at beat 10 of a 32-beat Get.
    task automatic test_reset_mid();
        set_a0(3'd4, 4'd7, 32'h0000_3000, 32'h0);
        m0_a_valid = 1'b1;
        tick();
        bus_a_ready = 1'b1;
        tick();
        bus_a_ready = 1'b0;
        m0_d_ready = 1'b1; bus_d_valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        n_checks++; if (m0_d_valid !== 1'b1 || bus_d_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_beat10: got m0_d_valid=%b d_ready=%b want 1 1", m0_d_valid, bus_d_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (m0_d_valid !== 1'b0 || m1_d_valid !== 1'b0 || bus_d_ready !== 1'b0 || bus_a_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got m0dv=%b m1dv=%b dr=%b av=%b want 0 0 0 0", m0_d_valid, m1_d_valid, bus_d_ready, bus_a_valid); end
        tick();
        clear_inputs();
        rst = 1'b0;
        set_a1(3'd0, 4'd2, 32'h0000_4000, 32'h0000_0055);
        m1_a_valid = 1'b1;
        tick();
        n_checks++; if (bus_a_valid !== 1'b1 || bus_a_address !== 32'h0000_4000) begin n_fail++; $display("FAIL rmid_regrant: got valid=%b addr=%h want 1 00004000", bus_a_valid, bus_a_address); end
        bus_a_ready = 1'b1;
        tick();
        m1_a_valid = 1'b0; bus_a_ready = 1'b0;
        m1_d_ready = 1'b1; bus_d_valid = 1'b1;
        tick();
        n_checks++; if (bus_d_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_one_beat: got %b want 0", bus_d_ready); end
        clear_inputs();
        tick();
    endtask

    // Get size 1 (2 bytes) on a 4-byte bus: one beat only.
    task automatic test_small_get();
        set_a0(3'd4, 4'd1, 32'h0000_5002, 32'h0);
        m0_a_valid = 1'b1;
        tick();
        bus_a_ready = 1'b1;
        tick();
        m0_a_valid = 1'b0; bus_a_ready = 1'b0;
        m0_d_ready = 1'b1; bus_d_valid = 1'b1;
        #1;
        n_checks++; if (bus_d_ready !== 1'b1 || m0_d_valid !== 1'b1) begin n_fail++; $display("FAIL small_first: got d_ready=%b m0_d_valid=%b want 1 1", bus_d_ready, m0_d_valid); end
        tick();
        n_checks++; if (bus_d_ready !== 1'b0 || m0_d_valid !== 1'b0) begin n_fail++; $display("FAIL small_second: got d_ready=%b m0_d_valid=%b want 0 0", bus_d_ready, m0_d_valid); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_get_burst();
        test_put_backpressure();
        test_tie_arbitration();
        test_d_backpressure();
        test_reset_mid();
        test_small_get();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
